// File: rtl/axis_testpattern_checker_pkg.sv
// Shared definitions for the AXIS counter test pattern: sequence arithmetic,
// the backpressure LFSR polynomial and the checker state encoding.
package axis_tp_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tp_state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // The extra carry bit keeps x + incr from wrapping before the END comparison.
  function automatic logic [63:0] tp_next(input logic [63:0] x,
                                          input logic [63:0] start,
                                          input logic [63:0] stop,
                                          input logic [63:0] incr);
    logic [64:0] sum;
    sum = {1'b0, x} + {1'b0, incr};
    if (sum > {1'b0, stop}) begin
      return start;
    end else begin
      return sum[63:0];
    end
  endfunction

  function automatic logic tp_in_range(input logic [63:0] x,
                                       input logic [63:0] start,
                                       input logic [63:0] stop,
                                       input logic [63:0] incr);
    return (x >= start) && (x <= stop) && (((x - start) % incr) == 64'd0);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    if (c == 32'hFFFF_FFFF) begin
      return c;
    end else begin
      return c + 32'd1;
    end
  endfunction

endpackage

// File: rtl/axis_testpattern_checker_if.sv
// AXI-Stream data channel between the pattern source and the checker.
interface axis_testpattern_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_testpattern_checker_lfsr16.sv
// Free-running 16-bit Galois LFSR used to throttle tready.
module lfsr16
  import axis_tp_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic [15:0] state_r;

  // advance one step every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEED;
    end else if (state_r[0]) begin
      state_r <= (state_r >> 1) ^ LFSR_POLY;
    end else begin
      state_r <= state_r >> 1;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXIS sink that locks onto the counter test pattern, predicts each beat and
// counts accepted beats and mismatches.
module axis_testpattern_checker
  import axis_tp_pkg::*;
#(
  parameter int unsigned S00_AXIS_TDATA_WIDTH = 32,
  parameter logic [63:0] COUNTER_START        = 64'd0,
  parameter logic [63:0] COUNTER_END          = 64'd255,
  parameter logic [63:0] COUNTER_INCR         = 64'd1,
  parameter int unsigned BACKPRESSURE         = 0,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      enable,
  input  logic                      clear,
  axis_testpattern_checker_if.slave s_axis,
  output logic                      locked,
  output logic                      error,
  output logic [31:0]               beat_count,
  output logic [31:0]               error_count
);

  localparam int unsigned W = S00_AXIS_TDATA_WIDTH;

  tp_state_e   state_r;
  logic        tready_r;
  logic        locked_r;
  logic        error_r;
  logic [31:0] beat_cnt_r;
  logic [31:0] err_cnt_r;
  logic [W-1:0] expected_r;

  logic         stall_ok_s;
  logic         accept_s;
  logic         in_range_s;
  logic         match_s;
  logic [W-1:0] next_data_s;
  logic [W-1:0] next_exp_s;

  generate
    if (BACKPRESSURE != 0) begin : g_bp
      logic [15:0] lfsr_s;
      lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .state (lfsr_s)
      );
      // stall whenever the low nibble is zero
      assign stall_ok_s = ((lfsr_s & 16'h000F) != 16'h0000);
    end else begin : g_nobp
      assign stall_ok_s = 1'b1;
    end
  endgenerate

  // beat acceptance and sequence prediction
  always_comb begin
    accept_s    = s_axis.tvalid & tready_r;
    in_range_s  = tp_in_range(64'(s_axis.tdata), COUNTER_START, COUNTER_END, COUNTER_INCR);
    match_s     = (s_axis.tdata == expected_r);
    next_data_s = W'(tp_next(64'(s_axis.tdata), COUNTER_START, COUNTER_END, COUNTER_INCR));
    next_exp_s  = W'(tp_next(64'(expected_r), COUNTER_START, COUNTER_END, COUNTER_INCR));
  end

  // checker state machine, counters and registered outputs
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_r    <= SEARCH;
      tready_r   <= 1'b0;
      locked_r   <= 1'b0;
      error_r    <= 1'b0;
      beat_cnt_r <= 32'd0;
      err_cnt_r  <= 32'd0;
      expected_r <= W'(COUNTER_START);
    end else begin
      tready_r <= enable & stall_ok_s;
      error_r  <= 1'b0;
      if (clear) begin
        state_r    <= SEARCH;
        locked_r   <= 1'b0;
        beat_cnt_r <= 32'd0;
        err_cnt_r  <= 32'd0;
        expected_r <= W'(COUNTER_START);
      end else if (accept_s) begin
        beat_cnt_r <= sat_inc32(beat_cnt_r);
        case (state_r)
          SEARCH: begin
            if (in_range_s) begin
              expected_r <= next_data_s;
              state_r    <= LOCKED;
              locked_r   <= 1'b1;
            end else begin
              state_r    <= SEARCH;
            end
          end
          LOCKED: begin
            if (match_s) begin
              expected_r <= next_exp_s;
            end else begin
              error_r   <= 1'b1;
              err_cnt_r <= sat_inc32(err_cnt_r);
              // an in-range value resyncs in place; garbage drops back to SEARCH
              if (in_range_s) begin
                expected_r <= next_data_s;
              end else begin
                state_r  <= SEARCH;
                locked_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r  <= SEARCH;
            locked_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign s_axis.tready = tready_r;
  assign locked        = locked_r;
  assign error         = error_r;
  assign beat_count    = beat_cnt_r;
  assign error_count   = err_cnt_r;

endmodule
